bcd_dabble16_seq: RTL and testbench

Sequential 16-bit unsigned binary to 5-digit packed BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It sits downstream of the binary arithmetic datapath and feeds the BCD display and readout path. It is the clocked, handshaked counterpart of the combinational BCD converters, and replaces the wide compare/subtract chain with a small iterative datapath.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_dabble_step.sv | 22 ++
 rtl/bcd_dabble16_seq.sv | 81 ++++++++
 tb/tb_bcd_dabble16_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converters.
package bcd_pkg;
  localparam int BCD_DIGITS = 5;
  localparam int BIN_W      = 16;

  typedef logic [BCD_DIGITS-1:0][3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Significant digits: position of the highest non-zero digit, never below 1.
  function automatic logic [2:0] digit_count(input bcd_t v);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 0; i < BCD_DIGITS; i++)
      if (v[i] != 4'd0) n = 3'(i + 1);
    return n;
  endfunction
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left by 1.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [4*BCD_DIGITS+BIN_W-1:0] d,
  output logic [4*BCD_DIGITS+BIN_W-1:0] q
);
  localparam int W = 4*BCD_DIGITS + BIN_W;

  bcd_t             adj_dig;
  logic [W-1:0]     adj;

  // A nibble <= 9 plus 3 fits in 4 bits, so the carry-out is simply dropped.
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dig
    logic [3:0] nib;
    assign nib        = d[BIN_W + 4*g +: 4];
    assign adj_dig[g] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  assign adj = {adj_dig, d[BIN_W-1:0]};
  assign q   = {adj[W-2:0], 1'b0};
endmodule

// File: rtl/bcd_dabble16_seq.sv
// Sequential 16-bit binary to 5-digit packed BCD converter, one dabble step per clock,
// with valid/ready handshakes on both sides.
module bcd_dabble16_seq #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIN_W-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [2:0]          out_ndigits,
  output logic                busy
);
  import bcd_pkg::*;

  localparam int W = 4*DIGITS + BIN_W;

  state_e       state;
  logic [W-1:0] work;
  logic [W-1:0] step_q;
  logic [4:0]   cnt;
  logic         accept;
  logic         last_iter;

  bcd_dabble_step u_step (
    .d (work),
    .q (step_q)
  );

  // DONE can hand its slot straight to a new input on the edge the result leaves.
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_SHIFT);
  assign last_iter = (cnt == 5'(BIN_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      work        <= '0;
      cnt         <= '0;
      out_bcd     <= '0;
      out_ndigits <= 3'd1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            work  <= {{(4*DIGITS){1'b0}}, in_data};
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          work <= step_q;
          cnt  <= cnt + 5'd1;
          if (last_iter) begin
            out_bcd     <= step_q[W-1:BIN_W];
            out_ndigits <= digit_count(step_q[W-1:BIN_W]);
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            if (accept) begin
              work  <= {{(4*DIGITS){1'b0}}, in_data};
              cnt   <= '0;
              state <= ST_SHIFT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_dabble16_seq.sv
// Directed and randomized checks of bcd_dabble16_seq against a decimal-division reference.
module tb_bcd_dabble16_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_bcd;
  logic [2:0]  out_ndigits;
  logic        busy;

  int tests = 0;
  int fails = 0;

  bcd_dabble16_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_bcd     (out_bcd),
    .out_ndigits (out_ndigits),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_nd(input int v);
    if (v >= 10000) return 3'd5;
    if (v >= 1000)  return 3'd4;
    if (v >= 100)   return 3'd3;
    if (v >= 10)    return 3'd2;
    return 3'd1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Single conversion from IDLE, checking latency, result and the return to IDLE.
  task automatic run_one(input logic [15:0] v, input logic [19:0] eb, input logic [2:0] en,
                         input string tag);
    int n;
    in_data = v; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check({tag, " latency"}, 32'(n), 32'd16);
    check({tag, " bcd"}, 32'(out_bcd), 32'(eb));
    check({tag, " ndigits"}, 32'(out_ndigits), 32'(en));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle valid"}, 32'(out_valid), 32'd0);
    check({tag, " idle ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n, first, second, cyc, sent, got;
    logic acc, ohs;
    logic [19:0] exp_b;
    logic [2:0]  exp_n;
    logic [22:0] q[$];
    logic [22:0] e;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_bcd", 32'(out_bcd), 32'd0);
    check("rst ndigits", 32'(out_ndigits), 32'd1);
    rst_n = 1'b1;
    tick();
    check("post-rst in_ready", 32'(in_ready), 32'd1);

    run_one(16'd0,     20'h00000, 3'd1, "zero");
    run_one(16'd65535, 20'h65535, 3'd5, "max");
    run_one(16'd1234,  20'h01234, 3'd4, "1234");
    run_one(16'd9,     20'h00009, 3'd1, "nine");

    // Back-pressure: result must freeze and new inputs must be refused.
    in_data = 16'd40960; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_data = 16'd123;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    check("bp latency", 32'(n), 32'd16);
    for (int i = 0; i < 10; i++) begin
      check("bp bcd", 32'(out_bcd), 32'h40960);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_valid", 32'(out_valid), 32'd1);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp handshake valid", 32'(out_valid), 32'd0);
    check("bp handshake busy", 32'(busy), 32'd0);
    tick();
    check("bp single valid", 32'(out_valid), 32'd0);
    check("bp hold bcd", 32'(out_bcd), 32'h40960);
    out_ready = 1'b0;

    // Back-to-back: second input accepted on the DONE-exit edge.
    in_data = 16'd9999; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_data = 16'd10000;
    cyc = 0; first = -1; second = -1;
    while (cyc < 60 && second < 0) begin
      tick(); cyc++;
      if (busy && first >= 0) in_valid = 1'b0;
      if (out_valid) begin
        if (first < 0) begin
          first = cyc;
          check("b2b bcd0", 32'(out_bcd), 32'h09999);
          check("b2b nd0", 32'(out_ndigits), 32'd4);
        end else begin
          second = cyc;
          check("b2b bcd1", 32'(out_bcd), 32'h10000);
          check("b2b nd1", 32'(out_ndigits), 32'd5);
        end
      end
    end
    check("b2b first latency", 32'(first), 32'd16);
    check("b2b spacing", 32'(second - first), 32'd17);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of a conversion.
    in_data = 16'd54321; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("mid busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst busy", 32'(busy), 32'd0);
    check("mid rst bcd", 32'(out_bcd), 32'd0);
    check("mid rst nd", 32'(out_ndigits), 32'd1);
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (out_valid) n++; end
    check("mid rst no valid", 32'(n), 32'd0);
    check("mid rst in_ready", 32'(in_ready), 32'd1);
    check("mid rst bcd hold", 32'(out_bcd), 32'd0);
    run_one(16'd54321, 20'h54321, 3'd5, "after rst");

    // Random stream with stalls on both sides, scored against the reference.
    sent = 0; got = 0; cyc = 0;
    while ((sent < 2000 || q.size() > 0) && cyc < 90000) begin
      if (!in_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 16'($urandom_range(0, 65535));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc = in_valid && in_ready;
      ohs = out_valid && out_ready;
      if (ohs) begin
        if (q.size() == 0) check("rand duplicate", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          check("rand result", {9'd0, out_ndigits, out_bcd}, {9'd0, e});
          got++;
        end
      end
      if (acc) begin
        exp_b = ref_bcd(int'(in_data));
        exp_n = ref_nd(int'(in_data));
        q.push_back({exp_n, exp_b});
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin sent++; in_valid = 1'b0; end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand received", 32'(got), 32'd2000);
    check("rand drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
